// File: rtl/ram_seq_ctrl.sv
// Host-to-RAM sequencer: zero-fills the array after reset, then runs single-word read/write requests.
// Latency accept->ack is WR_CYCLES (write) or RD_CYCLES (read); requests are only taken while idle (busy=0).
module ram_seq_ctrl #(
  parameter int AW        = 2,
  parameter int DW        = 4,
  parameter int WR_CYCLES = 1,
  parameter int RD_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic                  req,
  input  logic                  we,
  input  logic [AW-1:0]         addr,
  input  logic [DW-1:0]         wdata,
  output logic                  busy,
  output logic                  ack,
  output logic [DW-1:0]         rdata,
  output logic                  mem_rw,
  output logic [(2**AW)-1:0]    mem_end,
  output logic [DW-1:0]         mem_inp,
  input  logic [DW-1:0]         mem_y
);

  localparam int DEPTH = 2**AW;
  localparam int CMAX  = (WR_CYCLES > RD_CYCLES) ? WR_CYCLES : RD_CYCLES;
  localparam int CW    = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [CW-1:0]    WR_LAST  = CW'(WR_CYCLES - 1);
  localparam logic [CW-1:0]    RD_LAST  = CW'(RD_CYCLES - 1);
  localparam logic [AW-1:0]    IDX_LAST = AW'(DEPTH - 1);
  localparam logic [DEPTH-1:0] ONE      = DEPTH'(1);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             ack_q, ack_d;
  logic [DW-1:0]    rdata_q, rdata_d;
  logic             mem_rw_q, mem_rw_d;
  logic [DEPTH-1:0] mem_end_q, mem_end_d;
  logic [DW-1:0]    mem_inp_q, mem_inp_d;

  always_ff @(posedge clk) begin
    if (!clear) begin
      state_q   <= S_INIT;
      idx_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b1;
      ack_q     <= 1'b0;
      rdata_q   <= '0;
      mem_rw_q  <= 1'b0;
      mem_end_q <= '0;
      mem_inp_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
      mem_rw_q  <= mem_rw_d;
      mem_end_q <= mem_end_d;
      mem_inp_q <= mem_inp_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    ack_d     = 1'b0;
    rdata_d   = rdata_q;
    mem_rw_d  = mem_rw_q;
    mem_end_d = mem_end_q;
    mem_inp_d = mem_inp_q;

    case (state_q)
      S_INIT: begin
        // An all-zero strobe means the sweep has not started since reset.
        if (mem_end_q == '0) begin
          mem_end_d = ONE << idx_q;
          mem_rw_d  = 1'b1;
          mem_inp_d = '0;
          cnt_d     = '0;
        end else if (cnt_q != WR_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end else if (idx_q != IDX_LAST) begin
          idx_d     = idx_q + 1'b1;
          cnt_d     = '0;
          mem_end_d = ONE << idx_d;
        end else begin
          state_d   = S_IDLE;
          idx_d     = '0;
          cnt_d     = '0;
          mem_rw_d  = 1'b0;
          mem_end_d = '0;
          mem_inp_d = '0;
        end
      end

      S_IDLE: begin
        mem_rw_d  = 1'b0;
        mem_end_d = '0;
        mem_inp_d = '0;
        if (req) begin
          cnt_d     = '0;
          mem_end_d = ONE << addr;
          if (we) begin
            state_d   = S_WRITE;
            mem_rw_d  = 1'b1;
            mem_inp_d = wdata;
          end else begin
            state_d = S_READ;
          end
        end
      end

      S_WRITE: begin
        if (cnt_q == WR_LAST) begin
          state_d   = S_DONE;
          ack_d     = 1'b1;
          mem_rw_d  = 1'b0;
          mem_end_d = '0;
          mem_inp_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_READ: begin
        // mem_y is sampled on the last edge the word enable is still asserted.
        if (cnt_q == RD_LAST) begin
          state_d   = S_DONE;
          ack_d     = 1'b1;
          rdata_d   = mem_y;
          mem_end_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_INIT;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign busy    = busy_q;
  assign ack     = ack_q;
  assign rdata   = rdata_q;
  assign mem_rw  = mem_rw_q;
  assign mem_end = mem_end_q;
  assign mem_inp = mem_inp_q;

endmodule

// File: tb/tb_ram_seq_ctrl.sv
// Bench for ram_seq_ctrl: default instance with scoreboard, a WR_CYCLES=3 instance for
// reset-during-write, and an AW=3/DW=8 instance for the parameter variant.
module tb_ram_seq_ctrl;

  localparam int WR_A = 1;
  localparam int RD_A = 2;
  localparam int WR_B = 2;
  localparam int RD_B = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic       we;
    logic [7:0] data;
    int         ack_cyc;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  // ---------------- instance A (defaults)
  logic       clear_a, req_a, we_a, busy_a, ack_a, mem_rw_a;
  logic [1:0] addr_a;
  logic [3:0] wdata_a, rdata_a, mem_end_a, mem_inp_a, mem_y_a;
  logic [3:0] ram_a [4];
  logic [3:0] ref_a [4];
  int         ack_cnt_a = 0;
  logic       saw3 = 1'b0;

  ram_seq_ctrl #(.AW(2), .DW(4), .WR_CYCLES(WR_A), .RD_CYCLES(RD_A)) dut_a (
    .clk(clk), .clear(clear_a), .req(req_a), .we(we_a), .addr(addr_a), .wdata(wdata_a),
    .busy(busy_a), .ack(ack_a), .rdata(rdata_a), .mem_rw(mem_rw_a), .mem_end(mem_end_a),
    .mem_inp(mem_inp_a), .mem_y(mem_y_a)
  );

  always @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (mem_end_a[i] && mem_rw_a) ram_a[i] <= mem_inp_a;

  always_comb begin
    mem_y_a = '0;
    for (int i = 0; i < 4; i++)
      if (mem_end_a[i]) mem_y_a = mem_y_a | ram_a[i];
  end

  // ---------------- instance B (AW=3, DW=8, WR=2, RD=1)
  logic       clear_b, req_b, we_b, busy_b, ack_b, mem_rw_b;
  logic [2:0] addr_b;
  logic [7:0] wdata_b, rdata_b, mem_end_b, mem_inp_b, mem_y_b;
  logic [7:0] ram_b [8];
  logic [7:0] ref_b [8];

  ram_seq_ctrl #(.AW(3), .DW(8), .WR_CYCLES(WR_B), .RD_CYCLES(RD_B)) dut_b (
    .clk(clk), .clear(clear_b), .req(req_b), .we(we_b), .addr(addr_b), .wdata(wdata_b),
    .busy(busy_b), .ack(ack_b), .rdata(rdata_b), .mem_rw(mem_rw_b), .mem_end(mem_end_b),
    .mem_inp(mem_inp_b), .mem_y(mem_y_b)
  );

  always @(posedge clk)
    for (int i = 0; i < 8; i++)
      if (mem_end_b[i] && mem_rw_b) ram_b[i] <= mem_inp_b;

  always_comb begin
    mem_y_b = '0;
    for (int i = 0; i < 8; i++)
      if (mem_end_b[i]) mem_y_b = mem_y_b | ram_b[i];
  end

  // ---------------- instance C (WR=3), reset during a write
  logic       clear_c, req_c, we_c, busy_c, ack_c, mem_rw_c;
  logic [1:0] addr_c;
  logic [3:0] wdata_c, rdata_c, mem_end_c, mem_inp_c, mem_y_c;
  logic       ack_seen_c = 1'b0;

  ram_seq_ctrl #(.AW(2), .DW(4), .WR_CYCLES(3), .RD_CYCLES(2)) dut_c (
    .clk(clk), .clear(clear_c), .req(req_c), .we(we_c), .addr(addr_c), .wdata(wdata_c),
    .busy(busy_c), .ack(ack_c), .rdata(rdata_c), .mem_rw(mem_rw_c), .mem_end(mem_end_c),
    .mem_inp(mem_inp_c), .mem_y(mem_y_c)
  );

  // ---------------- scoreboard monitors
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (ack_a) begin
      ack_cnt_a++;
      chk("a_ack_expected", q_a.size() != 0, 1'b1);
      if (q_a.size() != 0) begin
        e = q_a.pop_front();
        chk("a_ack_cycle", cyc, e.ack_cyc);
        if (!e.we) chk("a_rdata", rdata_a, e.data);
      end
    end
    if (mem_end_a[3] && mem_rw_a) saw3 = 1'b1;
    chk("a_onehot0", $onehot0(mem_end_a), 1'b1);
    chk("a_rw_without_end", mem_rw_a && (mem_end_a == 4'b0), 1'b0);
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (ack_b) begin
      chk("b_ack_expected", q_b.size() != 0, 1'b1);
      if (q_b.size() != 0) begin
        e = q_b.pop_front();
        chk("b_ack_cycle", cyc, e.ack_cyc);
        if (!e.we) chk("b_rdata", rdata_b, e.data);
      end
    end
    chk("b_onehot0", $onehot0(mem_end_b), 1'b1);
  end

  always @(negedge clk)
    if (ack_c) ack_seen_c = 1'b1;

  // ---------------- host tasks (called at a negedge)
  task automatic issue_a(input logic w, input logic [1:0] a, input logic [3:0] d);
    exp_t e;
    int t = 0;
    while (busy_a && t < 100) begin @(negedge clk); t++; end
    chk("a_issue_idle", busy_a, 1'b0);
    req_a = 1'b1; we_a = w; addr_a = a; wdata_a = d;
    e.we      = w;
    e.data    = {4'b0, ref_a[a]};
    e.ack_cyc = cyc + 1 + (w ? WR_A : RD_A);
    q_a.push_back(e);
    if (w) ref_a[a] = d;
    @(negedge clk);
    req_a = 1'b0;
  endtask

  task automatic issue_b(input logic w, input logic [2:0] a, input logic [7:0] d);
    exp_t e;
    int t = 0;
    while (busy_b && t < 100) begin @(negedge clk); t++; end
    chk("b_issue_idle", busy_b, 1'b0);
    req_b = 1'b1; we_b = w; addr_b = a; wdata_b = d;
    e.we      = w;
    e.data    = ref_b[a];
    e.ack_cyc = cyc + 1 + (w ? WR_B : RD_B);
    q_b.push_back(e);
    if (w) ref_b[a] = d;
    @(negedge clk);
    req_b = 1'b0;
  endtask

  task automatic wait_idle_a();
    int t = 0;
    @(negedge clk);
    while (busy_a && t < 100) begin @(negedge clk); t++; end
    chk("a_wait_idle", busy_a, 1'b0);
  endtask

  task automatic wait_idle_b();
    int t = 0;
    @(negedge clk);
    while (busy_b && t < 100) begin @(negedge clk); t++; end
    chk("b_wait_idle", busy_b, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d of %0d checks failed", n_fail, n_tests);
    $fatal(1);
  end

  initial begin
    int   t;
    int   n;
    int   acks0;
    exp_t e;

    clear_a = 1'b0; req_a = 1'b0; we_a = 1'b0; addr_a = '0; wdata_a = '0;
    clear_b = 1'b0; req_b = 1'b0; we_b = 1'b0; addr_b = '0; wdata_b = '0;
    clear_c = 1'b0; req_c = 1'b0; we_c = 1'b0; addr_c = '0; wdata_c = '0; mem_y_c = '0;
    for (int i = 0; i < 4; i++) ref_a[i] = '0;
    for (int i = 0; i < 8; i++) ref_b[i] = '0;

    // Reset state after two edges with clear low
    @(negedge clk);
    @(negedge clk);
    chk("a_rst_busy", busy_a, 1'b1);
    chk("a_rst_ack", ack_a, 1'b0);
    chk("a_rst_rdata", rdata_a, 4'h0);
    chk("a_rst_end", mem_end_a, 4'h0);
    chk("a_rst_rw", mem_rw_a, 1'b0);
    chk("a_rst_inp", mem_inp_a, 4'h0);
    chk("c_rst_rdata", rdata_c, 4'h0);

    // Zero-fill sweep
    clear_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("a_init_end", mem_end_a, 32'd1 << i);
      chk("a_init_rw", mem_rw_a, 1'b1);
      chk("a_init_inp", mem_inp_a, 4'h0);
      chk("a_init_busy", busy_a, 1'b1);
    end
    @(negedge clk);
    chk("a_init_done_busy", busy_a, 1'b0);
    chk("a_init_done_end", mem_end_a, 4'h0);
    chk("a_init_done_rw", mem_rw_a, 1'b0);

    // Write addr 2 = 1101
    issue_a(1'b1, 2'd2, 4'b1101);
    chk("a_wr_end", mem_end_a, 4'b0100);
    chk("a_wr_rw", mem_rw_a, 1'b1);
    chk("a_wr_inp", mem_inp_a, 4'b1101);
    chk("a_wr_busy", busy_a, 1'b1);
    @(negedge clk);
    chk("a_wr_ack", ack_a, 1'b1);
    chk("a_wr_end_off", mem_end_a, 4'h0);
    chk("a_wr_rw_off", mem_rw_a, 1'b0);
    @(negedge clk);
    chk("a_wr_ack_off", ack_a, 1'b0);
    chk("a_wr_busy_off", busy_a, 1'b0);

    // Read addr 2, then a write to addr 0 must not disturb rdata
    issue_a(1'b0, 2'd2, 4'h0);
    chk("a_rd_end1", mem_end_a, 4'b0100);
    chk("a_rd_rw1", mem_rw_a, 1'b0);
    @(negedge clk);
    chk("a_rd_end2", mem_end_a, 4'b0100);
    chk("a_rd_ack_early", ack_a, 1'b0);
    @(negedge clk);
    chk("a_rd_ack", ack_a, 1'b1);
    chk("a_rd_rdata", rdata_a, 4'b1101);
    chk("a_rd_end_off", mem_end_a, 4'h0);
    issue_a(1'b1, 2'd0, 4'b0110);
    wait_idle_a();
    chk("a_rdata_hold", rdata_a, 4'b1101);
    chk("a_ram0", ram_a[0], 4'b0110);

    // Request pulsed while busy is ignored
    acks0 = ack_cnt_a;
    saw3  = 1'b0;
    issue_a(1'b0, 2'd1, 4'h0);
    req_a = 1'b1; we_a = 1'b1; addr_a = 2'd3; wdata_a = 4'hF;
    @(negedge clk);
    req_a = 1'b0;
    wait_idle_a();
    repeat (3) @(negedge clk);
    chk("a_blk_acks", ack_cnt_a - acks0, 1);
    chk("a_blk_no_w3", saw3, 1'b0);
    chk("a_blk_ram3", ram_a[3], 4'h0);

    // req held high: second accept two cycles after the first ack
    req_a = 1'b1; we_a = 1'b0; addr_a = 2'd1;
    e.we = 1'b0; e.data = {4'b0, ref_a[1]}; e.ack_cyc = cyc + 1 + RD_A;
    q_a.push_back(e);
    t = 0;
    while (!ack_a && t < 20) begin @(negedge clk); t++; end
    chk("a_hold_ack_seen", ack_a, 1'b1);
    e.ack_cyc = cyc + 2 + RD_A;
    q_a.push_back(e);
    @(negedge clk);
    chk("a_hold_gap_busy", busy_a, 1'b0);
    @(negedge clk);
    chk("a_hold_reaccept", mem_end_a, 4'b0010);
    req_a = 1'b0;
    wait_idle_a();

    // Mixed random traffic
    for (int k = 0; k < 10; k++) begin
      issue_a(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
      wait_idle_a();
    end
    repeat (2) @(negedge clk);
    chk("a_pending", q_a.size(), 0);

    // Instance C: reset during the second cycle of a 3-cycle write
    clear_c = 1'b1;
    t = 0;
    @(negedge clk);
    while (busy_c && t < 40) begin @(negedge clk); t++; end
    chk("c_init_done", busy_c, 1'b0);
    req_c = 1'b1; we_c = 1'b1; addr_c = 2'd1; wdata_c = 4'hA;
    @(negedge clk);
    req_c = 1'b0;
    chk("c_wr_end", mem_end_c, 4'b0010);
    chk("c_wr_inp", mem_inp_c, 4'hA);
    @(negedge clk);
    chk("c_wr_end2", mem_end_c, 4'b0010);
    clear_c = 1'b0;
    @(negedge clk);
    chk("c_rst_rw", mem_rw_c, 1'b0);
    chk("c_rst_end", mem_end_c, 4'h0);
    chk("c_rst_busy", busy_c, 1'b1);
    clear_c = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("c_reinit_w0", mem_end_c, 4'b0001);
    end
    @(negedge clk);
    chk("c_reinit_w1", mem_end_c, 4'b0010);
    t = 0;
    while (busy_c && t < 40) begin @(negedge clk); t++; end
    chk("c_reinit_done", busy_c, 1'b0);
    repeat (4) @(negedge clk);
    chk("c_ack_never", ack_seen_c, 1'b0);

    // Instance B: 16-cycle sweep, write then read addr 7
    clear_b = 1'b1;
    n = 0;
    t = 0;
    @(negedge clk);
    while (busy_b && t < 40) begin
      if (mem_end_b != 8'h0) n++;
      @(negedge clk);
      t++;
    end
    chk("b_init_len", n, 16);
    chk("b_init_busy", busy_b, 1'b0);
    issue_b(1'b1, 3'd7, 8'hA5);
    chk("b_wr_end", mem_end_b, 8'h80);
    chk("b_wr_inp", mem_inp_b, 8'hA5);
    wait_idle_b();
    issue_b(1'b0, 3'd7, 8'h00);
    chk("b_rd_end", mem_end_b, 8'h80);
    wait_idle_b();
    chk("b_rdata", rdata_b, 8'hA5);
    issue_b(1'b0, 3'd3, 8'h00);
    wait_idle_b();
    chk("b_rdata_zero", rdata_b, 8'h00);
    repeat (2) @(negedge clk);
    chk("b_pending", q_b.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
